// File: rtl/game_board_writer_if.sv
// rtl/game_board_writer_if.sv - command handshake bundle between the input decoder and game_board_writer
// Signals:
//   cmd_valid  command present (source)
//   cmd_ready  writer can accept a command (sink)
//   cmd_op     opcode: 0 NOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 WRITE, 6 ERASE, 7 CLEAR
//   cmd_value  digit for WRITE
//   cmd_fixed  WRITE marks the cell as a puzzle given
// Modports: master = command source, slave = game_board_writer.
interface game_board_writer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [4:0] cmd_value;
  logic       cmd_fixed;

  modport master (output cmd_valid, output cmd_op, output cmd_value, output cmd_fixed,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_value, input  cmd_fixed,
                  output cmd_ready);
endinterface

// File: rtl/game_board_writer.sv
// rtl/game_board_writer.sv - 16x16 game board storage with cursor/digit editing commands
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   board_size    sub-grid size N (clamped to 2..4), sampled at reset and CLEAR
//   cmd           command handshake (slave side)
//   board         registered cell values [row][col], 0 = empty
//   fixed         registered fixed-cell mask [row][col]
//   cursor_x/_y   cursor column / row
//   side          latched side length (4, 9 or 16)
//   err           one-cycle pulse after a rejected command
module game_board_writer (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             board_size,
  game_board_writer_if.slave     cmd,
  output logic [15:0][15:0][4:0] board,
  output logic [15:0][15:0]      fixed,
  output logic [3:0]             cursor_x,
  output logic [3:0]             cursor_y,
  output logic [4:0]             side,
  output logic                   err
);
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_UP    = 3'd1;
  localparam logic [2:0] OP_DOWN  = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;
  localparam logic [2:0] OP_WRITE = 3'd5;
  localparam logic [2:0] OP_ERASE = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  state_t                  state_q, state_d;
  logic [3:0]              row_q, row_d;
  logic [3:0]              cx_q, cx_d;
  logic [3:0]              cy_q, cy_d;
  logic [4:0]              side_q, side_d;
  logic                    err_q, err_d;
  logic [15:0][15:0][4:0]  board_q, board_d;
  logic [15:0][15:0]       fixed_q, fixed_d;

  logic [4:0] side_sel;
  logic       accept;
  logic [4:0] cx5, cy5, cx_inc, cy_inc;
  logic       cell_fixed;

  // Clamped N squared: N<=2 -> 4, N==3 -> 9, N>=4 -> 16.
  always_comb begin
    if (board_size <= 3'd2)      side_sel = 5'd4;
    else if (board_size == 3'd3) side_sel = 5'd9;
    else                         side_sel = 5'd16;
  end

  assign cmd.cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    side_d  = side_q;
    err_d   = 1'b0;
    board_d = board_q;
    fixed_d = fixed_q;

    cx5        = {1'b0, cx_q};
    cy5        = {1'b0, cy_q};
    cx_inc     = cx5 + 5'd1;
    cy_inc     = cy5 + 5'd1;
    cell_fixed = fixed_q[cy_q][cx_q];

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_UP:    cy_d = (cy5 == 5'd0) ? 4'(side_q - 5'd1) : 4'(cy5 - 5'd1);
            OP_DOWN:  cy_d = (cy_inc >= side_q) ? 4'd0 : 4'(cy_inc);
            OP_LEFT:  cx_d = (cx5 == 5'd0) ? 4'(side_q - 5'd1) : 4'(cx5 - 5'd1);
            OP_RIGHT: cx_d = (cx_inc >= side_q) ? 4'd0 : 4'(cx_inc);
            OP_WRITE: begin
              if (cmd.cmd_value == 5'd0 || cmd.cmd_value > side_q || cell_fixed) begin
                err_d = 1'b1;
              end else begin
                board_d[cy_q][cx_q] = cmd.cmd_value;
                fixed_d[cy_q][cx_q] = cmd.cmd_fixed;
              end
            end
            OP_ERASE: begin
              if (cell_fixed) err_d = 1'b1;
              else            board_d[cy_q][cx_q] = 5'd0;
            end
            OP_CLEAR: begin
              side_d  = side_sel;
              cx_d    = 4'd0;
              cy_d    = 4'd0;
              row_d   = 4'd0;
              state_d = S_CLEAR;
            end
            default: ; // OP_NOP
          endcase
        end
      end
      S_CLEAR: begin
        // One row per cycle; row counter wraps back to 0 after row 15.
        board_d[row_q] = '0;
        fixed_d[row_q] = '0;
        row_d          = row_q + 4'd1;
        if (row_q == 4'd15) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= 4'd0;
      cx_q    <= 4'd0;
      cy_q    <= 4'd0;
      side_q  <= side_sel;
      err_q   <= 1'b0;
      board_q <= '0;
      fixed_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      side_q  <= side_d;
      err_q   <= err_d;
      board_q <= board_d;
      fixed_q <= fixed_d;
    end
  end

  assign board    = board_q;
  assign fixed    = fixed_q;
  assign cursor_x = cx_q;
  assign cursor_y = cy_q;
  assign side     = side_q;
  assign err      = err_q;
endmodule

// File: tb/tb_game_board_writer.sv
// tb/tb_game_board_writer.sv - scoreboard bench for game_board_writer
module tb_game_board_writer;
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_UP    = 3'd1;
  localparam logic [2:0] OP_DOWN  = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;
  localparam logic [2:0] OP_WRITE = 3'd5;
  localparam logic [2:0] OP_ERASE = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [2:0]             board_size;
  logic [15:0][15:0][4:0] board;
  logic [15:0][15:0]      fixed;
  logic [3:0]             cursor_x, cursor_y;
  logic [4:0]             side;
  logic                   err;

  game_board_writer_if bus();

  game_board_writer dut (
    .clk        (clk),
    .rst        (rst),
    .board_size (board_size),
    .cmd        (bus),
    .board      (board),
    .fixed      (fixed),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .side       (side),
    .err        (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model of the board and cursor.
  int m_board [16][16];
  bit m_fixed [16][16];
  int m_cx, m_cy, m_side;

  typedef struct {
    string tag;
    int    cx, cy, err, row, col, val, fx, side;
  } exp_t;
  exp_t sb[$];

  function automatic int side_of(input int bs);
    int n;
    n = (bs < 2) ? 2 : ((bs > 4) ? 4 : bs);
    return n * n;
  endfunction

  function automatic void model_clear(input int bs);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        m_board[r][c] = 0;
        m_fixed[r][c] = 1'b0;
      end
    m_cx   = 0;
    m_cy   = 0;
    m_side = side_of(bs);
  endfunction

  function automatic exp_t model_apply(input int op, input int val, input bit f, input string tag);
    exp_t e;
    e.tag = tag;
    e.err = 0;
    e.row = m_cy;
    e.col = m_cx;
    case (op)
      OP_UP:    m_cy = (m_cy + m_side - 1) % m_side;
      OP_DOWN:  m_cy = (m_cy + 1) % m_side;
      OP_LEFT:  m_cx = (m_cx + m_side - 1) % m_side;
      OP_RIGHT: m_cx = (m_cx + 1) % m_side;
      OP_WRITE: begin
        if (val < 1 || val > m_side || m_fixed[m_cy][m_cx]) e.err = 1;
        else begin
          m_board[m_cy][m_cx] = val;
          m_fixed[m_cy][m_cx] = f;
        end
      end
      OP_ERASE: begin
        if (m_fixed[m_cy][m_cx]) e.err = 1;
        else m_board[m_cy][m_cx] = 0;
      end
      OP_CLEAR: model_clear(int'(board_size));
      default: ;
    endcase
    if (op == OP_UP || op == OP_DOWN || op == OP_LEFT || op == OP_RIGHT) begin
      e.row = m_cy;
      e.col = m_cx;
    end
    // Rows are cleared after the accept edge, so no cell check for CLEAR.
    if (op == OP_CLEAR) e.row = -1;
    else begin
      e.val = m_board[e.row][e.col];
      e.fx  = int'(m_fixed[e.row][e.col]);
    end
    e.cx   = m_cx;
    e.cy   = m_cy;
    e.side = m_side;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic do_cmd(input logic [2:0] op, input logic [4:0] val, input logic f, input string tag);
    int   waited;
    exp_t e;
    waited        = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_value = val;
    bus.cmd_fixed = f;
    while (!bus.cmd_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.cmd_ready) begin
      check({tag, "_accept_timeout"}, 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    sb.push_back(model_apply(int'(op), int'(val), f, tag));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_cx"},   cursor_x, e.cx);
    check({e.tag, "_cy"},   cursor_y, e.cy);
    check({e.tag, "_err"},  err,      e.err);
    check({e.tag, "_side"}, side,     e.side);
    if (e.row >= 0) begin
      check({e.tag, "_cell"},  board[e.row][e.col], e.val);
      check({e.tag, "_fixed"}, fixed[e.row][e.col], e.fx);
    end
  endtask

  task automatic check_board(input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (board[r][c] !== 5'(m_board[r][c]) || fixed[r][c] !== m_fixed[r][c]) bad++;
    check(tag, bad, 0);
  endtask

  function automatic int row_nonzero(input int r);
    int n;
    n = 0;
    for (int c = 0; c < 16; c++)
      if (board[r][c] != 5'd0 || fixed[r][c] != 1'b0) n++;
    return n;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    rst           = 1'b1;
    board_size    = 3'd3;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_value = 5'd0;
    bus.cmd_fixed = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_in_reset", bus.cmd_ready, 0);
    rst = 1'b0;
    model_clear(3);
    #1;
    check("reset_ready", bus.cmd_ready, 1);
    check("reset_side", side, 9);
    check("reset_cx", cursor_x, 0);
    check("reset_cy", cursor_y, 0);
    check("reset_err", err, 0);
    check_board("reset_board");
    @(negedge clk);

    // Wrap-around at side 9.
    do_cmd(OP_LEFT,  0, 0, "wrap_left");
    do_cmd(OP_UP,    0, 0, "wrap_up");
    do_cmd(OP_RIGHT, 0, 0, "wrap_right");
    do_cmd(OP_DOWN,  0, 0, "wrap_down");

    // Write validation at (2,1).
    do_cmd(OP_RIGHT, 0, 0, "mv_r1");
    do_cmd(OP_RIGHT, 0, 0, "mv_r2");
    do_cmd(OP_DOWN,  0, 0, "mv_d1");
    do_cmd(OP_WRITE, 9, 0, "write_9");
    do_cmd(OP_WRITE, 10, 0, "write_10");
    do_cmd(OP_WRITE, 0, 0, "write_0");
    do_cmd(OP_NOP,   0, 0, "nop_err_clears");

    // Fixed protection at (3,3), then plain erase at (4,3).
    do_cmd(OP_RIGHT, 0, 0, "mv_r3");
    do_cmd(OP_DOWN,  0, 0, "mv_d2");
    do_cmd(OP_DOWN,  0, 0, "mv_d3");
    do_cmd(OP_WRITE, 5, 1, "write_fixed");
    do_cmd(OP_ERASE, 0, 0, "erase_fixed");
    do_cmd(OP_WRITE, 7, 0, "write_over_fixed");
    do_cmd(OP_RIGHT, 0, 0, "mv_r4");
    do_cmd(OP_WRITE, 4, 0, "write_4");
    do_cmd(OP_ERASE, 0, 0, "erase_4");
    do_cmd(OP_ERASE, 0, 0, "erase_empty");
    check_board("board_before_clear");

    // board_size change only takes effect at CLEAR.
    board_size = 3'd4;
    do_cmd(OP_NOP,   0, 0, "nop_after_bs");
    do_cmd(OP_CLEAR, 0, 0, "clear");
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_value = 5'd3;
    bus.cmd_fixed = 1'b0;
    low = 0;
    for (int k = 0; k < 16; k++) begin
      if (!bus.cmd_ready) low++;
      if (k == 3) check("row3_not_yet_cleared", board[3][3], 5);
      @(negedge clk);
      check($sformatf("clear_row%0d", k), row_nonzero(k), 0);
    end
    check("clear_ready_low_cycles", low, 16);
    check("clear_ready_back", bus.cmd_ready, 1);
    check("held_write_not_early", board[0][0], 0);
    do_cmd(OP_WRITE, 3, 0, "held_write");
    check_board("board_after_clear");

    // Side 16 boundaries.
    do_cmd(OP_LEFT,  0, 0, "s16_left");
    do_cmd(OP_WRITE, 16, 0, "s16_write16");
    do_cmd(OP_WRITE, 17, 0, "s16_write17");
    do_cmd(OP_UP,    0, 0, "s16_up");
    do_cmd(OP_DOWN,  0, 0, "s16_down");
    repeat (4) do_cmd(OP_UP, 0, 0, "s16_up_to12");
    do_cmd(OP_WRITE, 2, 0, "write_row12");

    // Reset while clearing row 7; reset also resamples board_size (1 clamps to 2).
    do_cmd(OP_CLEAR, 0, 0, "clear2");
    board_size = 3'd1;
    repeat (7) @(negedge clk);
    check("row12_before_abort", board[12][15], 2);
    rst = 1'b1;
    @(negedge clk);
    model_clear(1);
    check("abort_ready_in_reset", bus.cmd_ready, 0);
    check_board("abort_board");
    check("abort_side", side, 4);
    rst = 1'b0;
    #1;
    check("abort_ready_after", bus.cmd_ready, 1);
    @(negedge clk);
    do_cmd(OP_LEFT,  0, 0, "s4_left");
    do_cmd(OP_WRITE, 5, 0, "s4_write5");
    do_cmd(OP_WRITE, 4, 1, "s4_write4");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/game_board_writer.md
# game_board_writer

Owns the 16x16 game board storage that the on-screen board renderers read: it accepts single-cycle editing commands (cursor moves, digit writes, erases, whole-board clear) and updates the board array plus a per-cell "fixed" mask. It is the write side of the `board` array consumed by the board number drawer. It sits in the `clk` domain between the input decoder (keyboard/mouse command generator) and the VGA draw chain.

## Interface

Parameters:
- None. Board storage is fixed at 16x16 cells of 5 bits.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `board_size`  in  3  sub-grid size N. Clamped: values <2 are treated as 2, values >4 as 4. Side = N*N, giving 4, 9 or 16.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  3  opcode: 0 NOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 WRITE, 6 ERASE, 7 CLEAR.
- `cmd_value`  in  5  digit for WRITE. Valid range is 1..side.
- `cmd_fixed`  in  1  with WRITE: marks the cell fixed (puzzle givens).
- `board`  out  [4:0] [15:0][15:0]  registered cell values, indexed [row][col]. 0 = empty.
- `fixed`  out  [15:0][15:0]  registered fixed mask.
- `cursor_x`, `cursor_y`  out  4  cursor column and row.
- `side`  out  5  latched active side length (4, 9 or 16).
- `err`  out  1  one-cycle pulse for a rejected command.

## Operation

- States: IDLE and CLEAR. `cmd_ready` = (state==IDLE) && !rst. It is combinational from state.
- Accept condition: `cmd_valid && cmd_ready` at a rising edge. Effects of an accepted command are visible on the outputs after that edge.
- UP: `cursor_y` - 1, wrapping from 0 to side-1.
- DOWN: `cursor_y` + 1, wrapping from side-1 to 0.
- LEFT and RIGHT: the same rules applied to `cursor_x`.
- Moves never assert `err`.
- WRITE:
  - If `cmd_value`==0, or `cmd_value`>side, or `fixed[cy][cx]`==1: assert `err` and make no change.
  - Otherwise: `board[cy][cx]` <= `cmd_value` and `fixed[cy][cx]` <= `cmd_fixed`.
- ERASE:
  - If the cell is fixed: assert `err`.
  - Otherwise: `board[cy][cx]` <= 0.
  - Erasing an already empty cell is legal and does not assert `err`.
- CLEAR, at the acceptance edge:
  - `side` <= clamp(`board_size`)², cursor <= (0,0), row counter <= 0, state -> CLEAR.
  - In CLEAR, each edge zeroes `board[r][*]` and `fixed[r][*]` for row r = row counter, then increments r.
  - After the edge that clears row 15, state -> IDLE.
- NOP: accepted, no effect, no `err`.
- `board_size` is sampled only at reset and at CLEAR acceptance. Changes at any other time have no effect until the next CLEAR.
- Cells outside side x side are never written except by clear/reset. They stay 0.
- `err` is registered: high for exactly the one cycle after the rejecting edge, otherwise 0.
- Arithmetic:
  - Cursor math is done in 5 bits and compared against `side`.
  - The `cmd_value` > side compare is done in 5 bits, unsigned.

## Timing

- Reset (rst high at an edge) sets:
  - all `board` = 0 and all `fixed` = 0
  - cursor (0,0)
  - `side` = clamp(`board_size`)²
  - state IDLE, `err` = 0
- `cmd_ready` is 0 during every cycle in which rst is high.
- Command latency: 1 edge from acceptance to updated outputs.
- Throughput in IDLE: one command per cycle.
- CLEAR timing:
  - `cmd_ready` drops in the cycle after acceptance and stays low for exactly 16 cycles.
  - Row r reads 0 after edge r+1 following acceptance.
  - `cmd_ready` returns high after edge 16.
- Commands presented while `cmd_ready`=0 are not accepted and leave no side effects. The source holds `cmd_valid` and its payload stable until acceptance.
- Reset asserted mid-CLEAR aborts the clear. The reset values apply at that edge.
- Back-to-back commands of the form move-then-WRITE use the updated cursor. This holds because the cursor is a register updated at the accept edge.

## Test plan

- Reset with `board_size`=3:
  - Required: `side`=9, cursor (0,0), all cells 0, `cmd_ready`=1 from the first cycle after rst deasserts.
- Wrap-around with side=9:
  - Stimulus: LEFT at (0,0), then UP.
  - Required: cursor (8,0) then (8,8).
  - Stimulus: then RIGHT and DOWN.
  - Required: cursor back to (0,0). No `err`.
- Write validation with side=9 at (2,1):
  - WRITE value 9 -> `board[1][2]`=9.
  - WRITE value 10 -> `err` pulse, cell stays 9.
  - WRITE value 0 -> `err` pulse, cell stays 9.
- Fixed protection:
  - Stimulus: WRITE 5 with `cmd_fixed`=1 at (3,3), then ERASE, then WRITE 7.
  - Required: both later commands pulse `err`, cell stays 5 and fixed.
  - Required: ERASE on a non-fixed cell holding 4 -> 0, no `err`.
- CLEAR, after filling several cells:
  - Stimulus: change `board_size` to 4, then issue CLEAR.
  - Required: `cmd_ready` low for exactly 16 cycles, row r zero after edge r+1, `side`=16 after acceptance, a held WRITE is accepted only on the 17th cycle.
- Reset mid-CLEAR:
  - Stimulus: assert rst at clear row 7.
  - Required: all cells 0 on the next cycle, state IDLE, `cmd_ready`=1 once rst deasserts.
